// File: rtl/tdp_ram_param_if.sv
// ---------------------------------------------------------------------------
// tdp_ram_param_if
//   Bundle of the two access ports plus the clear-engine handshake of the
//   shared scratch RAM. clk/rst are not part of the bundle.
//
//   Parameters: WIDTH (data bits), DEPTH (words); ADDR_W is derived.
//   Signals:
//     clr, busy                          clear request / clear engine active
//     a_en, a_we, a_addr, a_din          port A request
//     a_dout, a_valid                    port A read return
//     b_en, b_we, b_addr, b_din          port B request
//     b_dout, b_valid                    port B read return
//     collision                          both ports wrote the same word
//   Modports: master (the requesting side), slave (the RAM).
// ---------------------------------------------------------------------------
interface tdp_ram_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

  logic              clr;
  logic              busy;
  logic              a_en;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [WIDTH-1:0]  a_din;
  logic [WIDTH-1:0]  a_dout;
  logic              a_valid;
  logic              b_en;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_din;
  logic [WIDTH-1:0]  b_dout;
  logic              b_valid;
  logic              collision;

  modport master (
    output clr, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    input  busy, a_dout, a_valid, b_dout, b_valid, collision
  );

  modport slave (
    input  clr, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    output busy, a_dout, a_valid, b_dout, b_valid, collision
  );
endinterface

// File: rtl/tdp_ram_param.sv
// ---------------------------------------------------------------------------
// tdp_ram_param
//   Single-clock true dual-port RAM used as shared scratch store between two
//   masters. Configurable width/depth, cross-port read-during-write mode,
//   port-A-wins write arbitration with a collision pulse, read latency of 1
//   or 2 cycles with valid strobes, and a word-by-word clear engine.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset (control and output registers;
//           memory contents are left untouched)
//     bus   tdp_ram_param_if.slave: clr/busy, port A, port B, collision
//
//   Parameters:
//     WIDTH    data width (>=1)
//     DEPTH    number of words (>=2, any value)
//     RD_LAT   1 or 2 cycles from accepting edge to data
//     RDW_MODE 0 = reader sees old word, 1 = reader sees the other port's din
// ---------------------------------------------------------------------------
module tdp_ram_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  tdp_ram_param_if.slave  bus
);
  localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  // Request decode
  logic a_in_rng, a_acc, a_wr, a_rd;
  logic b_in_rng, b_acc, b_wr, b_rd, b_wr_eff;
  logic same_addr;
  logic [WIDTH-1:0] a_rdata, b_rdata;

  // Clear engine
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              clr_wr;

  // First output stage and collision flag
  logic [WIDTH-1:0] a_dout_p0_q, a_dout_p0_d;
  logic [WIDTH-1:0] b_dout_p0_q, b_dout_p0_d;
  logic             a_vld_p0_q, a_vld_p0_d;
  logic             b_vld_p0_q, b_vld_p0_d;
  logic             collision_q, collision_d;

  always_comb begin
    a_in_rng  = ({1'b0, bus.a_addr} < DEPTH_C);
    b_in_rng  = ({1'b0, bus.b_addr} < DEPTH_C);
    a_acc     = bus.a_en & ~busy_q;
    b_acc     = bus.b_en & ~busy_q;
    a_wr      = a_acc &  bus.a_we & a_in_rng;
    b_wr      = b_acc &  bus.b_we & b_in_rng;
    a_rd      = a_acc & ~bus.a_we;
    b_rd      = b_acc & ~bus.b_we;
    same_addr = (bus.a_addr == bus.b_addr);
    // Port A owns the word when both ports write it in the same cycle.
    b_wr_eff  = b_wr & ~(a_wr & same_addr);
  end

  // Read data: out-of-range reads return zero; a cross-port write to the
  // same word either is invisible (read-first) or forwards its din.
  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    if (a_in_rng) begin
      if (RDW_MODE == 1 && b_wr && same_addr) a_rdata = bus.b_din;
      else                                    a_rdata = mem[bus.a_addr];
    end
    if (b_in_rng) begin
      if (RDW_MODE == 1 && a_wr && same_addr) b_rdata = bus.a_din;
      else                                    b_rdata = mem[bus.b_addr];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    clr_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_wr = 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Memory array has no reset. Clear writes never overlap port writes
  // because ports are blocked while busy.
  always_ff @(posedge clk) begin
    if (clr_wr)   mem[cnt_q]      <= '0;
    if (b_wr_eff) mem[bus.b_addr] <= bus.b_din;
    if (a_wr)     mem[bus.a_addr] <= bus.a_din;
  end

  // ---- stage p0: capture read data at the accepting edge ----
  always_comb begin
    a_dout_p0_d = a_rd ? a_rdata : a_dout_p0_q;
    b_dout_p0_d = b_rd ? b_rdata : b_dout_p0_q;
    a_vld_p0_d  = a_rd;
    b_vld_p0_d  = b_rd;
    collision_d = a_wr & b_wr & same_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout_p0_q <= '0;
      b_dout_p0_q <= '0;
      a_vld_p0_q  <= 1'b0;
      b_vld_p0_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_dout_p0_q <= a_dout_p0_d;
      b_dout_p0_q <= b_dout_p0_d;
      a_vld_p0_q  <= a_vld_p0_d;
      b_vld_p0_q  <= b_vld_p0_d;
      collision_q <= collision_d;
    end
  end

  // ---- stage p1: optional output register for two-cycle latency ----
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] a_dout_p1_q, a_dout_p1_d;
      logic [WIDTH-1:0] b_dout_p1_q, b_dout_p1_d;
      logic             a_vld_p1_q, a_vld_p1_d;
      logic             b_vld_p1_q, b_vld_p1_d;

      always_comb begin
        a_dout_p1_d = a_vld_p0_q ? a_dout_p0_q : a_dout_p1_q;
        b_dout_p1_d = b_vld_p0_q ? b_dout_p0_q : b_dout_p1_q;
        a_vld_p1_d  = a_vld_p0_q;
        b_vld_p1_d  = b_vld_p0_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_dout_p1_q <= '0;
          b_dout_p1_q <= '0;
          a_vld_p1_q  <= 1'b0;
          b_vld_p1_q  <= 1'b0;
        end else begin
          a_dout_p1_q <= a_dout_p1_d;
          b_dout_p1_q <= b_dout_p1_d;
          a_vld_p1_q  <= a_vld_p1_d;
          b_vld_p1_q  <= b_vld_p1_d;
        end
      end

      assign bus.a_dout  = a_dout_p1_q;
      assign bus.b_dout  = b_dout_p1_q;
      assign bus.a_valid = a_vld_p1_q;
      assign bus.b_valid = b_vld_p1_q;
    end else begin : g_lat1
      assign bus.a_dout  = a_dout_p0_q;
      assign bus.b_dout  = b_dout_p0_q;
      assign bus.a_valid = a_vld_p0_q;
      assign bus.b_valid = b_vld_p0_q;
    end
  endgenerate

  assign bus.busy      = busy_q;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_tdp_ram_param.sv
// ---------------------------------------------------------------------------
// tb_tdp_ram_param
//   Directed bench for tdp_ram_param. Four instances share one stimulus:
//     u0  DEPTH=4 RD_LAT=1 RDW_MODE=0
//     u1  DEPTH=4 RD_LAT=1 RDW_MODE=1
//     u2  DEPTH=4 RD_LAT=2 RDW_MODE=0
//     u3  DEPTH=6 RD_LAT=1 RDW_MODE=0
//   Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_tdp_ram_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdp_ram_param_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  tdp_ram_param_if #(.WIDTH(8), .DEPTH(4)) if1 ();
  tdp_ram_param_if #(.WIDTH(8), .DEPTH(4)) if2 ();
  tdp_ram_param_if #(.WIDTH(8), .DEPTH(6)) if3 ();

  assign if0.clr = clr;  assign if0.a_en = a_en; assign if0.a_we = a_we;
  assign if0.a_addr = a_addr[1:0]; assign if0.a_din = a_din;
  assign if0.b_en = b_en; assign if0.b_we = b_we;
  assign if0.b_addr = b_addr[1:0]; assign if0.b_din = b_din;

  assign if1.clr = clr;  assign if1.a_en = a_en; assign if1.a_we = a_we;
  assign if1.a_addr = a_addr[1:0]; assign if1.a_din = a_din;
  assign if1.b_en = b_en; assign if1.b_we = b_we;
  assign if1.b_addr = b_addr[1:0]; assign if1.b_din = b_din;

  assign if2.clr = clr;  assign if2.a_en = a_en; assign if2.a_we = a_we;
  assign if2.a_addr = a_addr[1:0]; assign if2.a_din = a_din;
  assign if2.b_en = b_en; assign if2.b_we = b_we;
  assign if2.b_addr = b_addr[1:0]; assign if2.b_din = b_din;

  assign if3.clr = clr;  assign if3.a_en = a_en; assign if3.a_we = a_we;
  assign if3.a_addr = a_addr; assign if3.a_din = a_din;
  assign if3.b_en = b_en; assign if3.b_we = b_we;
  assign if3.b_addr = b_addr; assign if3.b_din = b_din;

  tdp_ram_param #(.WIDTH(8), .DEPTH(4), .RD_LAT(1), .RDW_MODE(0))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  tdp_ram_param #(.WIDTH(8), .DEPTH(4), .RD_LAT(1), .RDW_MODE(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  tdp_ram_param #(.WIDTH(8), .DEPTH(4), .RD_LAT(2), .RDW_MODE(0))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  tdp_ram_param #(.WIDTH(8), .DEPTH(6), .RD_LAT(1), .RDW_MODE(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
  endtask

  task automatic wr_a(input logic [2:0] ad, input logic [7:0] d);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_din = d;
  endtask

  task automatic rd_a(input logic [2:0] ad);
    a_en = 1'b1; a_we = 1'b0; a_addr = ad;
  endtask

  task automatic wr_b(input logic [2:0] ad, input logic [7:0] d);
    b_en = 1'b1; b_we = 1'b1; b_addr = ad; b_din = d;
  endtask

  task automatic rd_b(input logic [2:0] ad);
    b_en = 1'b1; b_we = 1'b0; b_addr = ad;
  endtask

  initial begin
    // Reset values while rst is held
    @(negedge clk);
    chk("rst_a_dout",  if0.a_dout, 0);
    chk("rst_b_dout",  if0.b_dout, 0);
    chk("rst_a_valid", if0.a_valid, 0);
    chk("rst_b_valid", if0.b_valid, 0);
    chk("rst_coll",    if0.collision, 0);
    chk("rst_busy",    if0.busy, 0);
    rst = 1'b0;
    cyc();

    // A writes 0x5A to addr 2, then B reads it
    wr_a(3'd2, 8'h5A); cyc(); idle();
    chk("wr_no_valid", if0.a_valid, 0);
    rd_b(3'd2); cyc(); idle();
    chk("rd_b_data",  if0.b_dout, 8'h5A);
    chk("rd_b_valid", if0.b_valid, 1);
    cyc();
    chk("rd_b_strobe", if0.b_valid, 0);
    chk("rd_b_hold",   if0.b_dout, 8'h5A);

    // Cross-port read-during-write on addr 1 (old value 0x22)
    wr_a(3'd1, 8'h22); cyc();
    wr_a(3'd1, 8'h11); rd_b(3'd1); cyc(); idle();
    chk("rdw_old", if0.b_dout, 8'h22);
    chk("rdw_new", if1.b_dout, 8'h11);
    chk("rdw_vld", if0.b_valid, 1);
    rd_b(3'd1); cyc(); idle();
    chk("rdw_after", if0.b_dout, 8'h11);

    // Write collision on addr 3: A wins, one-cycle pulse
    wr_a(3'd3, 8'hAA); wr_b(3'd3, 8'hBB); cyc(); idle();
    chk("coll_hi", if0.collision, 1);
    cyc();
    chk("coll_lo", if0.collision, 0);
    rd_a(3'd3); cyc(); idle();
    chk("coll_winner", if0.a_dout, 8'hAA);

    // Back-to-back reads, latency 1 and latency 2
    for (int k = 0; k < 4; k++) begin
      wr_a(3'(k), 8'(k + 1)); cyc();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) rd_a(3'(i));
      else       idle();
      cyc();
      chk($sformatf("lat1_vld%0d", i), if0.a_valid, (i < 4) ? 1 : 0);
      if (i < 4) chk($sformatf("lat1_dat%0d", i), if0.a_dout, i + 1);
      chk($sformatf("lat2_vld%0d", i), if2.a_valid, (i >= 1 && i <= 4) ? 1 : 0);
      if (i >= 1) chk($sformatf("lat2_dat%0d", i), if2.a_dout, (i <= 4) ? i : 4);
    end

    // Clear engine: preload 0xFF, writes during busy are dropped
    for (int k = 0; k < 4; k++) begin
      wr_a(3'(k), 8'hFF); cyc();
    end
    idle();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_busy0", if0.busy, 1);
    for (int i = 1; i <= 4; i++) begin
      wr_a(3'(i - 1), 8'h77); cyc();
      chk($sformatf("clr_busy%0d", i), if0.busy, (i < 4) ? 1 : 0);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_a(3'(k)); cyc();
      chk($sformatf("clr_dat%0d", k), if0.a_dout, 0);
      chk($sformatf("clr_vld%0d", k), if0.a_valid, 1);
    end
    idle();
    cyc(); cyc(); cyc();
    chk("d6_idle", if3.busy, 0);

    // DEPTH=6: reset in the middle of a clear
    for (int k = 0; k < 6; k++) begin
      wr_a(3'(k), 8'(8'h30 + k)); cyc();
    end
    idle();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("d6_busy", if3.busy, 1);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("d6_rst_busy", if3.busy, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cyc(); cyc();
    chk("d6_no_resume", if3.busy, 0);
    for (int k = 0; k < 6; k++) begin
      rd_a(3'(k)); cyc();
      chk($sformatf("d6_dat%0d", k), if3.a_dout, (k < 3) ? 0 : 8'h30 + k);
    end
    rd_a(3'd7); cyc(); idle();
    chk("d6_oor_dat", if3.a_dout, 0);
    chk("d6_oor_vld", if3.a_valid, 1);
    wr_a(3'd6, 8'h99); wr_b(3'd6, 8'h98); cyc(); idle();
    chk("d6_oor_coll", if3.collision, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tdp_ram_param.md
Name: tdp_ram_param

Overview:
- Parametrised single-clock true dual-port RAM. Successor to the fixed 8-bit, 3-entry, dual-clock dual-port RAM.
- Adds the following:
  - configurable width and depth
  - separate enable and write-enable per port
  - selectable cross-port read-during-write mode
  - deterministic write-collision arbitration with a flag
  - selectable read latency with valid strobes
  - a hardware clear engine
- Sits as the shared scratch store between two masters in the same clock domain.

Parameters:
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of words, ≥2. Need not be a power of two.
- RD_LAT, 1: read latency in cycles. Legal values are 1 and 2.
- RDW_MODE, 0: cross-port read-during-write result. 0 = old data (read-first), 1 = new data (write-through).
- ADDR_W is a localparam equal to max(1, clog2(DEPTH)). It is not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  start the clear engine (level is sampled each cycle).
- busy  out  1  clear engine active; port requests are ignored while high.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) or read (0); qualified by a_en.
- a_addr  in  ADDR_W  port A word address.
- a_din  in  WIDTH  port A write data.
- a_dout  out  WIDTH  port A read data.
- a_valid  out  1  a_dout carries new read data this cycle.
- b_en, b_we, b_addr, b_din, b_dout, b_valid: port B, same widths and meanings as port A.
- collision  out  1  both ports wrote the same address (registered pulse).

Behaviour:
- Reset (async assert, takes effect immediately):
  - a_dout=0, b_dout=0, a_valid=0, b_valid=0, collision=0, busy=0.
  - FSM goes to IDLE; clear counter goes to 0.
  - Memory contents are not reset.
- Request acceptance:
  - A request is accepted when x_en=1 and busy=0 at the clock edge.
  - Requests with busy=1 are dropped: no write, no valid.
- Write:
  - mem[addr] <= din at that edge.
  - x_dout is unchanged; no valid.
- Read:
  - RD_LAT=1: x_dout is updated at the accepting edge; x_valid is high for the following cycle.
  - RD_LAT=2: one extra output register stage. Data and valid appear one cycle later.
  - Fully pipelined: one read per port per cycle. Back-to-back reads give continuous valid.
- x_dout holds its last value when no read completes. x_valid is a single-cycle strobe per read.
- Address out of range (addr ≥ DEPTH):
  - A write is discarded.
  - A read returns 0 with valid asserted.
  - collision is not raised.
- Cross-port, same cycle, same address, one port reads and the other writes:
  - RDW_MODE=0: the reader gets the pre-write word.
  - RDW_MODE=1: the reader gets the written din.
- Both ports write the same in-range address in the same cycle:
  - Port A's data is stored.
  - collision=1 for exactly the next cycle, then 0 unless repeated.
- Both ports read the same address: both get the same data, no collision.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on an edge with clr=1. The same edge sets busy=1 and cnt=0.
  - Port requests on that same edge are still accepted.
  - In CLEAR, each edge writes mem[cnt]=0 and increments cnt.
  - On the edge that writes cnt=DEPTH-1, the FSM returns to IDLE and busy goes to 0.
  - busy is high for exactly DEPTH cycles.
  - clr is ignored while in CLEAR.
  - Reads already in the RD_LAT=2 pipeline complete normally during CLEAR.
- Reset mid-clear:
  - Immediate return to IDLE, busy=0.
  - Words already cleared stay 0; the remaining words are unchanged.
  - No further clearing happens without a new clr.

Test Plan:
- WIDTH=8, DEPTH=4, RD_LAT=1: A writes 0x5A to addr 2, then B reads addr 2 → b_dout=0x5A with b_valid high for 1 cycle, one cycle after the read request.
- Same cycle, A writes 0x11 to addr 1 while B reads addr 1 (prior value 0x22) → RDW_MODE=0 gives b_dout=0x22; RDW_MODE=1 gives b_dout=0x11.
- A writes 0xAA and B writes 0xBB to addr 3 in the same cycle → collision=1 next cycle only; a later read of addr 3 returns 0xAA.
- RD_LAT=2: A reads addr 0,1,2,3 back-to-back (preloaded 1,2,3,4) → a_valid high for 4 consecutive cycles starting 2 cycles after the first request; data 1,2,3,4 in order.
- Preload all words with 0xFF, pulse clr for 1 cycle, issue A writes while busy → busy high for exactly 4 cycles, the writes are ignored, and all reads afterwards return 0x00.
- DEPTH=6: pulse clr, assert rst after 3 busy cycles → busy drops immediately; addr 0–2 read 0 and addr 3–5 keep old data. A read of addr 7 returns 0 with valid.
